// File: rtl/pad_in_conditioner.sv
// Pad input conditioner: per-bit resynchroniser, stability-counter debounce, rise/fall pulses.
// Optional sticky edge-interrupt logic is built when PAD_IN_EDGE_IRQ_EN is defined.
module pad_in_conditioner #(
  parameter int               WIDTH           = 1,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VAL       = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pad_y,
  input  logic             filt_en,
  output logic [WIDTH-1:0] filt,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`ifdef PAD_IN_EDGE_IRQ_EN
  ,
  input  logic [WIDTH-1:0] irq_mask,
  input  logic [WIDTH-1:0] irq_clr,
  output logic [WIDTH-1:0] irq_status,
  output logic             irq
`endif
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
  logic [CW-1:0]    cnt_reg  [WIDTH];
  logic [CW-1:0]    cnt_next [WIDTH];
  logic [WIDTH-1:0] filt_next;
  logic [WIDTH-1:0] s;
  logic             filt_en_reg;
  logic             en_change;

  assign s         = sync_reg[SYNC_STAGES-1];
  assign en_change = filt_en ^ filt_en_reg;

  // Entering filter mode only restarts the counters; filt keeps its level that edge.
  always_comb begin
    filt_next = filt;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (!filt_en) begin
        filt_next[i] = s[i];
      end else if (!en_change && (s[i] != filt[i])) begin
        if (cnt_reg[i] == CNT_LAST) begin
          filt_next[i] = s[i];
        end else begin
          cnt_next[i] = cnt_reg[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= RESET_VAL;
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_reg[i] <= '0;
      end
      filt        <= RESET_VAL;
      rise        <= '0;
      fall        <= '0;
      filt_en_reg <= 1'b1;
    end else begin
      sync_reg[0] <= pad_y;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_reg[i] <= cnt_next[i];
      end
      filt        <= filt_next;
      rise        <= filt_next & ~filt;
      fall        <= ~filt_next & filt;
      filt_en_reg <= filt_en;
    end
  end

`ifdef PAD_IN_EDGE_IRQ_EN
  // A new masked edge outranks a clear arriving on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_status <= '0;
      irq        <= 1'b0;
    end else begin
      irq_status <= (irq_status & ~irq_clr) | ((rise | fall) & irq_mask);
      irq        <= |irq_status;
    end
  end
`endif

endmodule
